// File: rtl/control_pipe.sv
// control_pipe: opcode decode, three-stage control bundle pipeline, load-use hazard and bubble counting
module control_pipe #(
    parameter int ALUOP_W   = 2,
    parameter int EN_HAZARD = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [4:0]         id_rd,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               stall_ext,
    input  logic               flush,
    output logic               ex_valid,
    output logic               ex_mem_rd,
    output logic               ex_mem_wr,
    output logic               ex_reg_wr,
    output logic [1:0]         ex_wb_sel,
    output logic               ex_mux_ula,
    output logic [ALUOP_W-1:0] ex_ula_op,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [4:0]         ex_rd,
    output logic               mem_valid,
    output logic               mem_mem_rd,
    output logic               mem_mem_wr,
    output logic               mem_reg_wr,
    output logic [1:0]         mem_wb_sel,
    output logic               mem_mux_ula,
    output logic [ALUOP_W-1:0] mem_ula_op,
    output logic               mem_branch,
    output logic               mem_jump,
    output logic [4:0]         mem_rd,
    output logic               wb_valid,
    output logic               wb_mem_rd,
    output logic               wb_mem_wr,
    output logic               wb_reg_wr,
    output logic [1:0]         wb_wb_sel,
    output logic               wb_mux_ula,
    output logic [ALUOP_W-1:0] wb_ula_op,
    output logic               wb_branch,
    output logic               wb_jump,
    output logic [4:0]         wb_rd,
    output logic               load_use_stall,
    output logic               ex_illegal,
    output logic [CNT_W-1:0]   bubble_cnt
);
    typedef struct packed {
        logic               valid;
        logic               mem_rd;
        logic               mem_wr;
        logic               reg_wr;
        logic [1:0]         wb_sel;
        logic               mux_ula;
        logic [ALUOP_W-1:0] ula_op;
        logic               branch;
        logic               jump;
        logic [4:0]         rd;
    } bundle_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    bundle_t          w_dec, r_ex, r_mem, r_wb;
    logic             w_legal, w_use1, w_use2, w_lus, w_bub, r_ill;
    logic [1:0]       w_op;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        w_use1  = 1'b1;
        w_use2  = 1'b0;
        w_op    = 2'b00;
        case (id_opcode)
            OP_R:             begin w_dec.reg_wr = 1'b1; w_op = 2'b10; w_use2 = 1'b1; end
            OP_I:             begin w_dec.reg_wr = 1'b1; w_dec.mux_ula = 1'b1; w_op = 2'b11; end
            OP_LD:            begin w_dec.mem_rd = 1'b1; w_dec.reg_wr = 1'b1; w_dec.mux_ula = 1'b1; w_dec.wb_sel = 2'b01; end
            OP_ST:            begin w_dec.mem_wr = 1'b1; w_dec.mux_ula = 1'b1; w_use2 = 1'b1; end
            OP_BR:            begin w_dec.branch = 1'b1; w_op = 2'b01; w_use2 = 1'b1; end
            OP_LUI, OP_AUIPC: begin w_dec.reg_wr = 1'b1; w_dec.mux_ula = 1'b1; w_use1 = 1'b0; end
            OP_JAL:           begin w_dec.jump = 1'b1; w_dec.reg_wr = 1'b1; w_dec.wb_sel = 2'b10; w_use1 = 1'b0; end
            OP_JALR:          begin w_dec.jump = 1'b1; w_dec.reg_wr = 1'b1; w_dec.mux_ula = 1'b1; w_dec.wb_sel = 2'b10; end
            default:          begin w_legal = 1'b0; w_use1 = 1'b0; end
        endcase
        w_dec.ula_op = ALUOP_W'(w_op);
        w_dec.valid  = id_valid & w_legal;
        w_dec.rd     = id_rd;
        w_dec.reg_wr = w_dec.reg_wr & (id_rd != 5'd0);
    end

    // Only a load in EX whose destination feeds a source actually read by the ID instruction stalls
    assign w_lus = (EN_HAZARD != 0) && !flush && !stall_ext && id_valid && r_ex.valid && r_ex.mem_rd
                   && (r_ex.rd != 5'd0)
                   && ((w_use1 && id_rs1 == r_ex.rd) || (w_use2 && id_rs2 == r_ex.rd));
    assign w_bub = flush || w_lus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
            r_ill <= 1'b0;
            r_cnt <= '0;
        end else if (!stall_ext) begin
            r_ex  <= (w_bub || !w_dec.valid) ? '0 : w_dec;
            r_ill <= !w_bub && id_valid && !w_legal;
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (w_bub && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign {ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd} = r_ex;
    assign {mem_valid, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_wb_sel, mem_mux_ula, mem_ula_op, mem_branch, mem_jump, mem_rd} = r_mem;
    assign {wb_valid, wb_mem_rd, wb_mem_wr, wb_reg_wr, wb_wb_sel, wb_mux_ula, wb_ula_op, wb_branch, wb_jump, wb_rd} = r_wb;
    assign load_use_stall = w_lus;
    assign ex_illegal     = r_ill;
    assign bubble_cnt     = r_cnt;
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed vectors with a WB scoreboard for control_pipe
module tb_control_pipe;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    // valid mem_rd mem_wr reg_wr wb_sel mux_ula ula_op branch jump
    localparam logic [10:0] ROW_R    = 11'b1_0_0_1_00_0_10_0_0;
    localparam logic [10:0] ROW_I    = 11'b1_0_0_1_00_1_11_0_0;
    localparam logic [10:0] ROW_LD   = 11'b1_1_0_1_01_1_00_0_0;
    localparam logic [10:0] ROW_ST   = 11'b1_0_1_0_00_1_00_0_0;
    localparam logic [10:0] ROW_BR   = 11'b1_0_0_0_00_0_01_1_0;
    localparam logic [10:0] ROW_LUI  = 11'b1_0_0_1_00_1_00_0_0;
    localparam logic [10:0] ROW_JAL  = 11'b1_0_0_1_10_0_00_0_1;
    localparam logic [10:0] ROW_JALR = 11'b1_0_0_1_10_1_00_0_1;
    localparam logic [15:0] LD_RD0   = {11'b1_1_0_0_01_1_00_0_0, 5'd0};
    localparam logic [15:0] R_RD0    = {11'b1_0_0_0_00_0_10_0_0, 5'd0};

    logic clk = 1'b0, rst_n;
    logic id_valid, stall_ext, flush;
    logic [6:0] id_opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_ula, ex_branch, ex_jump;
    logic mem_valid, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_mux_ula, mem_branch, mem_jump;
    logic wb_valid, wb_mem_rd, wb_mem_wr, wb_reg_wr, wb_mux_ula, wb_branch, wb_jump;
    logic [1:0] ex_wb_sel, mem_wb_sel, wb_wb_sel, ex_ula_op, mem_ula_op, wb_ula_op;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic load_use_stall, ex_illegal;
    logic [15:0] bubble_cnt;
    logic c_ex_valid, c_ex_mem_rd, c_ex_mem_wr, c_ex_reg_wr, c_ex_mux_ula, c_ex_branch, c_ex_jump;
    logic c_mem_valid, c_mem_mem_rd, c_mem_mem_wr, c_mem_reg_wr, c_mem_mux_ula, c_mem_branch, c_mem_jump;
    logic c_wb_valid, c_wb_mem_rd, c_wb_mem_wr, c_wb_reg_wr, c_wb_mux_ula, c_wb_branch, c_wb_jump;
    logic [1:0] c_ex_wb_sel, c_mem_wb_sel, c_wb_wb_sel, c_ex_ula_op, c_mem_ula_op, c_wb_ula_op;
    logic [4:0] c_ex_rd, c_mem_rd, c_wb_rd;
    logic c_lus, c_ill;
    logic [1:0] c_cnt;
    logic [15:0] ex_b, mem_b, wb_b;

    typedef struct {
        int          due;
        logic [15:0] b;
    } exp_t;
    exp_t q[$];
    int n_vec = 0, n_bad = 0, cyc = 0;
    logic adv = 1'b0;

    logic [6:0]  ops  [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    logic [10:0] rows [9] = '{ROW_R, ROW_I, ROW_LD, ROW_ST, ROW_BR, ROW_LUI, ROW_LUI, ROW_JAL, ROW_JALR};

    always #5 clk = ~clk;

    control_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .stall_ext(stall_ext), .flush(flush),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
        .ex_wb_sel(ex_wb_sel), .ex_mux_ula(ex_mux_ula), .ex_ula_op(ex_ula_op), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_reg_wr(mem_reg_wr),
        .mem_wb_sel(mem_wb_sel), .mem_mux_ula(mem_mux_ula), .mem_ula_op(mem_ula_op), .mem_branch(mem_branch),
        .mem_jump(mem_jump), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_mem_rd(wb_mem_rd), .wb_mem_wr(wb_mem_wr), .wb_reg_wr(wb_reg_wr),
        .wb_wb_sel(wb_wb_sel), .wb_mux_ula(wb_mux_ula), .wb_ula_op(wb_ula_op), .wb_branch(wb_branch),
        .wb_jump(wb_jump), .wb_rd(wb_rd),
        .load_use_stall(load_use_stall), .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
    );

    control_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .stall_ext(stall_ext), .flush(flush),
        .ex_valid(c_ex_valid), .ex_mem_rd(c_ex_mem_rd), .ex_mem_wr(c_ex_mem_wr), .ex_reg_wr(c_ex_reg_wr),
        .ex_wb_sel(c_ex_wb_sel), .ex_mux_ula(c_ex_mux_ula), .ex_ula_op(c_ex_ula_op), .ex_branch(c_ex_branch),
        .ex_jump(c_ex_jump), .ex_rd(c_ex_rd),
        .mem_valid(c_mem_valid), .mem_mem_rd(c_mem_mem_rd), .mem_mem_wr(c_mem_mem_wr), .mem_reg_wr(c_mem_reg_wr),
        .mem_wb_sel(c_mem_wb_sel), .mem_mux_ula(c_mem_mux_ula), .mem_ula_op(c_mem_ula_op), .mem_branch(c_mem_branch),
        .mem_jump(c_mem_jump), .mem_rd(c_mem_rd),
        .wb_valid(c_wb_valid), .wb_mem_rd(c_wb_mem_rd), .wb_mem_wr(c_wb_mem_wr), .wb_reg_wr(c_wb_reg_wr),
        .wb_wb_sel(c_wb_wb_sel), .wb_mux_ula(c_wb_mux_ula), .wb_ula_op(c_wb_ula_op), .wb_branch(c_wb_branch),
        .wb_jump(c_wb_jump), .wb_rd(c_wb_rd),
        .load_use_stall(c_lus), .ex_illegal(c_ill), .bubble_cnt(c_cnt)
    );

    assign ex_b  = {ex_valid, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel, ex_mux_ula, ex_ula_op, ex_branch, ex_jump, ex_rd};
    assign mem_b = {mem_valid, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_wb_sel, mem_mux_ula, mem_ula_op, mem_branch, mem_jump, mem_rd};
    assign wb_b  = {wb_valid, wb_mem_rd, wb_mem_wr, wb_reg_wr, wb_wb_sel, wb_mux_ula, wb_ula_op, wb_branch, wb_jump, wb_rd};

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid  = 1'b1;
        id_opcode = op;
        id_rd     = rd;
        id_rs1    = rs1;
        id_rs2    = rs2;
    endtask

    task automatic expect_wb(input logic [15:0] b, input int lat);
        exp_t e;
        e.due = cyc + lat;
        e.b   = b;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        adv <= rst_n && !stall_ext;
    end

    // WB monitor: every freshly advanced valid WB bundle must match the oldest expectation, on time
    always @(negedge clk) begin
        if (rst_n && adv && wb_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL wb_unexpected: got 0x%0h, expected no valid bundle", wb_b);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_bundle", wb_b, e.b);
                chk("wb_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        stall_ext = 1'b0; flush = 1'b0;
        tick(); tick();
        chk("rst_valid", {ex_valid, mem_valid, wb_valid}, 0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_illegal", ex_illegal, 0);
        drive(OP_R, 5, 3, 3); #1;
        chk("rst_lus", load_use_stall, 0);
        id_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(ops[i], 5, 1, 2);
            expect_wb({rows[i], 5'd5}, 3);
            tick();
            chk($sformatf("dec_ex_%0d", i), ex_b, {rows[i], 5'd5});
        end
        id_valid = 1'b0;
        repeat (3) tick();

        drive(OP_LD, 3, 1, 2); expect_wb({ROW_LD, 5'd3}, 3); tick();
        drive(OP_R, 6, 3, 2); #1;
        chk("lu_stall", load_use_stall, 1);
        expect_wb({ROW_R, 5'd6}, 4);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_release", load_use_stall, 0);
        tick();
        chk("lu_add_ex", ex_b, {ROW_R, 5'd6});
        id_valid = 1'b0;

        drive(OP_LD, 0, 1, 2); expect_wb(LD_RD0, 3); tick();
        drive(OP_R, 6, 0, 0); #1;
        chk("nh_rd0", load_use_stall, 0);
        expect_wb({ROW_R, 5'd6}, 3); tick();
        drive(OP_LD, 3, 1, 2); expect_wb({ROW_LD, 5'd3}, 3); tick();
        drive(OP_LUI, 4, 3, 3); #1;
        chk("nh_lui", load_use_stall, 0);
        expect_wb({ROW_LUI, 5'd4}, 3); tick();
        id_valid = 1'b0;
        repeat (3) tick();

        drive(OP_R, 7, 1, 2); expect_wb({ROW_R, 5'd7}, 5); tick();
        drive(OP_I, 8, 1, 2); expect_wb({ROW_I, 5'd8}, 5); tick();
        drive(OP_R, 9, 8, 8);
        stall_ext = 1'b1; flush = 1'b1;
        repeat (2) begin
            tick();
            chk("st_ex", ex_b, {ROW_I, 5'd8});
            chk("st_mem", mem_b, {ROW_R, 5'd7});
            chk("st_wb", wb_valid, 0);
            chk("st_cnt", bubble_cnt, 1);
        end
        stall_ext = 1'b0;
        tick();
        chk("fl_ex", ex_valid, 0);
        chk("fl_mem", mem_b, {ROW_I, 5'd8});
        chk("fl_cnt", bubble_cnt, 2);
        flush = 1'b0; id_valid = 1'b0;
        repeat (3) tick();

        drive(7'b1111111, 5, 1, 2); tick();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_reg_wr", ex_reg_wr, 0);
        chk("ill_valid", ex_valid, 0);
        drive(OP_R, 0, 1, 2); expect_wb(R_RD0, 3); tick();
        chk("ill_clear", ex_illegal, 0);
        chk("rd0_reg_wr", ex_reg_wr, 0);
        chk("rd0_valid", ex_valid, 1);
        id_valid = 1'b0;
        repeat (3) tick();

        drive(OP_R, 10, 1, 2); expect_wb({ROW_R, 5'd10}, 3); tick();
        drive(OP_I, 11, 1, 2); tick();
        drive(OP_LD, 12, 1, 2); tick();
        id_valid = 1'b0;
        chk("pre_rst_valid", {ex_valid, mem_valid, wb_valid}, 3'b111);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        chk("mid_rst_valid", {ex_valid, mem_valid, wb_valid}, 0);
        chk("mid_rst_cnt", bubble_cnt, 0);
        chk("mid_rst_illegal", ex_illegal, 0);
        tick();
        rst_n = 1'b1;

        flush = 1'b1;
        repeat (3) tick();
        chk("sat_at3", c_cnt, 3);
        repeat (2) tick();
        chk("cnt_wide5", bubble_cnt, 5);
        chk("sat_hold", c_cnt, 3);
        flush = 1'b0;
        tick();
        chk("q_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
